sub8_serial: RTL and testbench
==============================

Name: sub8_serial

Overview:
- Bit-serial 8-bit subtractor: the inverse operation to the team's 8-bit ripple adder.
- Computes x = a - b by iterating a single full-adder cell LSB-first over 8 clock cycles.
  - Operation is a + ~b with carry-in 1.
  - A borrow register replaces the ripple chain.
- Sits beside the ripple adder in the datapath wherever area matters more than latency.
- Uses a start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8, operand width in bits; result width is WIDTH+1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- x  output  WIDTH+1  result.
  - x[WIDTH-1:0] is the difference mod 2^WIDTH.
  - x[WIDTH] is the borrow (1 iff a<b).
  - Equivalently, x is the (WIDTH+1)-bit two's-complement value of a-b.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; x is valid and newly updated in that cycle.

Behaviour:
- Reset (async, active-high): state=IDLE, x=0, busy=0, done=0, bit counter=0, carry register=1, operand shift registers=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and x returns to 0.
- States:
  - IDLE: busy=0.
    - start=1 at an edge: capture a into sa, ~b into sb, and the zeroed result shift register; set carry=1 and count=0; go to SHIFT.
    - start=0: stay in IDLE.
  - SHIFT: busy=1. Each edge:
    - sum = sa[0]^sb[0]^carry.
    - carry <= majority(sa[0], sb[0], carry).
    - Shift sum into the result register MSB-side so that bit i lands in position i after WIDTH steps.
    - Shift sa and sb right by one.
    - Increment count.
    - On the edge where count reaches WIDTH-1, i.e. the WIDTH-th bit is processed:
      - load x <= {~carry_next, result}.
      - done <= 1, busy <= 0.
      - go to IDLE.
- Timing: start sampled at edge E0 → bits processed at E1..E8 → after E8, x valid, done=1, busy=0. Latency from the accepting edge to done is WIDTH cycles.
- done: high for exactly one cycle; cleared at the next edge.
- x: holds its value until the next completion or reset. It does not change during SHIFT.
- start while busy=1 is ignored: no queuing, operands not re-sampled. This includes the last SHIFT edge.
- start=1 during the done cycle is accepted, since busy=0 then. Back-to-back throughput is one result per WIDTH+1 cycles.
- a and b may change freely after the accepting edge without affecting the result.
- Borrow: x[WIDTH] = NOT final carry.
  - a>=b → final carry=1 → x[WIDTH]=0.
  - a<b → x[WIDTH]=1.
- No overflow condition exists: the 9-bit result always represents a-b exactly for unsigned 8-bit operands.

Test Plan:
- Basic: a=200 (0xC8), b=55 (0x37), pulse start → done exactly 8 cycles after the accepting edge, x=0x091, busy high for cycles 1-8.
- Negative/borrow and extremes:
  - a=3, b=5 → x=0x1FE.
  - a=0, b=255 → x=0x101.
  - a=0, b=0 → x=0x000.
  - a=255, b=0 → x=0x0FF.
- Handshake:
  - start held high continuously with a=10, b=4 → results x=0x006 repeat every 9 cycles.
  - Operands changed to a=1, b=2 during SHIFT → current result unaffected (0x006); next result 0x1FF.
- Ignored start: second start pulse with a=9, b=9 issued at busy cycles 3 and 8 → ignored; only the first result appears; one done pulse.
- Reset mid-operation: assert rst asynchronously (between edges) at busy cycle 4 → busy, done, x go to 0 immediately. After release, no done occurs until a new start; a new start with a=7, b=7 gives x=0x000.
- Random: 1000 random a/b pairs with random idle gaps → every done shows x == (a - b) mod 512, where a and b are the operands captured at acceptance.

Source files
------------

// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial subtractor, x = a - b via a + ~b + 1, LSB first.
// Ports: clk, rst (async high), start, a, b -> x (borrow & diff), busy, done.
module sub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   x,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n;
  logic [WIDTH-1:0] sb, sb_n;
  logic [WIDTH-1:0] res, res_n;
  logic [CW-1:0]    count, count_n;
  logic             carry, carry_n;
  logic [WIDTH:0]   x_n;
  logic             done_n;
  logic             sum, cout;

  // One full-adder cell; the carry register stands in for the ripple chain.
  assign sum  = sa[0] ^ sb[0] ^ carry;
  assign cout = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
  assign busy = (state == SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      res   <= '0;
      count <= '0;
      carry <= 1'b1;
      x     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      sa    <= sa_n;
      sb    <= sb_n;
      res   <= res_n;
      count <= count_n;
      carry <= carry_n;
      x     <= x_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    res_n   = res;
    count_n = count;
    carry_n = carry;
    x_n     = x;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          sa_n    = a;
          sb_n    = ~b;
          res_n   = '0;
          carry_n = 1'b1;
          count_n = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        carry_n = cout;
        // New bit enters at the MSB so bit i settles at position i.
        res_n   = {sum, res[WIDTH-1:1]};
        sa_n    = {1'b0, sa[WIDTH-1:1]};
        sb_n    = {1'b0, sb[WIDTH-1:1]};
        count_n = count + CW'(1);
        if (count == LAST) begin
          // Borrow is the inverse of the final carry out.
          x_n     = {~cout, sum, res[WIDTH-1:1]};
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sub8_serial.sv
// tb_sub8_serial: directed and random checks of sub8_serial.
// Drives on negedge, samples on negedge, all checks via chk.
module tb_sub8_serial;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [8:0] x;
  logic       busy;
  logic       done;

  int errs = 0;
  int nchk = 0;
  logic [8:0] xexp = '0;

  sub8_serial #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .x    (x),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept at next posedge, then follow the 8 busy cycles and the done cycle.
  // pmask[k]: pulse start (a=b=9) at busy cycle k+1, which must be ignored.
  task automatic op(input logic [7:0] av, input logic [7:0] bv,
                    input logic [8:0] ex, input string tag,
                    input logic [7:0] pmask);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 0) begin
        a = ~av;
        b = av;
      end
      if (k < 8) begin
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".nodone"}, done, 0);
        chk({tag, ".hold"}, x, xexp);
        if (pmask[k]) begin
          start = 1'b1;
          a = 8'd9;
          b = 8'd9;
        end
      end else begin
        xexp = ex;
        chk({tag, ".done"}, done, 1);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".x"}, x, ex);
      end
    end
    @(negedge clk);
    chk({tag, ".pulse"}, done, 0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [8:0] rx;
    int gap;

    @(negedge clk);
    chk("rst.x", x, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle.done", done, 0);

    op(8'd200, 8'd55, 9'h091, "basic", 8'h00);
    op(8'd3, 8'd5, 9'h1FE, "neg", 8'h00);
    op(8'd0, 8'd255, 9'h101, "min", 8'h00);
    op(8'd0, 8'd0, 9'h000, "zero", 8'h00);
    op(8'd255, 8'd0, 9'h0FF, "max", 8'h00);

    // Start pulses at busy cycles 3 and 8 are ignored.
    op(8'd100, 8'd1, 9'h063, "ign", 8'h84);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("ign.nodone", done, 0);
      chk("ign.xhold", x, 9'h063);
    end

    // Start held high: one result every 9 cycles; operands changed mid-run.
    start = 1'b1;
    a = 8'd10;
    b = 8'd4;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      if (k == 8 || k == 17) begin
        chk("hold.x", x, 9'h006);
        xexp = 9'h006;
      end
      if (k == 26) chk("hold.x2", x, 9'h1FF);
      chk("hold.done", done, (k == 8 || k == 17 || k == 26));
      chk("hold.busy", busy, !(k == 8 || k == 17 || k == 26));
      if (k == 12) begin
        a = 8'd1;
        b = 8'd2;
      end
      if (k == 26) start = 1'b0;
    end
    xexp = 9'h1FF;
    @(negedge clk);
    chk("hold.end", busy, 0);

    // Asynchronous reset between edges at busy cycle 4.
    @(negedge clk);
    start = 1'b1;
    a = 8'd200;
    b = 8'd55;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst = 1'b1;
    #1;
    chk("arst.busy", busy, 0);
    chk("arst.done", done, 0);
    chk("arst.x", x, 0);
    xexp = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("arst.nodone", done, 0);
    end
    op(8'd7, 8'd7, 9'h000, "post", 8'h00);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rx = {1'b0, ra} - {1'b0, rb};
      op(ra, rb, rx, "rand", 8'h00);
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
